// File: rtl/plcp_rx_pkg.sv
// Shared definitions for the 802.11a PLCP receive path.
package plcp_rx_pkg;

    typedef enum logic [2:0] {IDLE, SEED, SERVICE, DATA, TAIL, PAD} rx_state_t;

    localparam int unsigned SERVICE_BITS = 16;
    localparam int unsigned SEED_BITS    = 7;
    localparam int unsigned TAIL_BITS    = 6;

    localparam logic [7:0] NDBPS_LEGAL [8] = '{8'd24, 8'd36, 8'd48, 8'd72,
                                               8'd96, 8'd144, 8'd192, 8'd216};

    // True when n is one of the data-bits-per-symbol values of the OFDM rates.
    function automatic logic ndbps_legal(input logic [7:0] n);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ok = ok | (n == NDBPS_LEGAL[i]);
        end
        return ok;
    endfunction

endpackage

// File: rtl/descrambler_lfsr.sv
// 7-bit descrambler LFSR, S(x) = x^7 + x^4 + 1. State bit [6] holds lfsr[7].
module descrambler_lfsr (
    input  logic       Clock,
    input  logic       Reset_n,
    input  logic       Load,
    input  logic [6:0] Load_Value,
    input  logic       Step,
    output logic       Fb
);

    logic [6:0] lfsr_q;

    assign Fb = lfsr_q[6] ^ lfsr_q[3];

    // Load takes priority over stepping.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            lfsr_q <= 7'h7F;
        end else if (Load) begin
            lfsr_q <= Load_Value;
        end else if (Step) begin
            lfsr_q <= {lfsr_q[5:0], Fb};
        end
    end

endmodule

// File: rtl/descrambler_ctrl.sv
// Receive-side PLCP DATA sequencer: seed recovery, descrambling and PSDU framing.
module descrambler_ctrl
    import plcp_rx_pkg::*;
#(
    parameter int unsigned MAX_LEN = 4095
) (
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic        Start,
    input  logic [11:0] Length,
    input  logic [7:0]  Ndbps,
    input  logic        In_Valid,
    input  logic        In_Bit,
    output logic        Out_Valid,
    output logic        Out_Bit,
    output logic        Out_Last,
    output logic        Done,
    output logic        Busy,
    output logic [6:0]  Seed,
    output logic        Err,
    output logic        Service_Err
);

    rx_state_t   state_q, state_d;
    logic [11:0] len_q, len_d;
    logic [7:0]  ndbps_q, ndbps_d;
    logic [15:0] bit_cnt_q, bit_cnt_d;
    logic [7:0]  sym_cnt_q, sym_cnt_d;
    logic [6:0]  seed_q, seed_d;
    logic        out_valid_q, out_valid_d;
    logic        out_bit_q, out_bit_d;
    logic        out_last_q, out_last_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;
    logic        err_q, err_d;
    logic        svc_err_q, svc_err_d;

    logic        lfsr_load, lfsr_step, lfsr_fb;
    logic        desc_bit, sym_last, start_legal;
    logic [15:0] data_last, tail_last;

    descrambler_lfsr u_lfsr (
        .Clock      (Clock),
        .Reset_n    (Reset_n),
        .Load       (lfsr_load),
        .Load_Value (seed_d),
        .Step       (lfsr_step),
        .Fb         (lfsr_fb)
    );

    assign desc_bit    = In_Bit ^ lfsr_fb;
    assign sym_last    = (sym_cnt_q == ndbps_q - 8'd1);
    assign data_last   = {1'b0, len_q, 3'b000} + 16'(SERVICE_BITS - 1);
    assign tail_last   = data_last + 16'(TAIL_BITS);
    assign start_legal = (Length != 12'd0) && (32'(Length) <= MAX_LEN) && ndbps_legal(Ndbps);

    // Next-state, counters and registered strobes; strobes default low every cycle.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        ndbps_d     = ndbps_q;
        bit_cnt_d   = bit_cnt_q;
        sym_cnt_d   = sym_cnt_q;
        seed_d      = seed_q;
        busy_d      = busy_q;
        svc_err_d   = svc_err_q;
        out_valid_d = 1'b0;
        out_bit_d   = 1'b0;
        out_last_d  = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        lfsr_load   = 1'b0;
        lfsr_step   = 1'b0;

        if (state_q == IDLE) begin
            if (Start) begin
                svc_err_d = 1'b0;
                if (start_legal) begin
                    len_d     = Length;
                    ndbps_d   = Ndbps;
                    bit_cnt_d = '0;
                    sym_cnt_d = '0;
                    busy_d    = 1'b1;
                    state_d   = SEED;
                end else begin
                    err_d = 1'b1;
                end
            end
        end else if (In_Valid) begin
            bit_cnt_d = bit_cnt_q + 16'd1;
            sym_cnt_d = sym_last ? 8'd0 : sym_cnt_q + 8'd1;
            unique case (state_q)
                SEED: begin
                    seed_d = {seed_q[5:0], In_Bit};
                    if (bit_cnt_q == 16'(SEED_BITS - 1)) begin
                        lfsr_load = 1'b1;
                        if (seed_d == 7'd0) begin
                            err_d   = 1'b1;
                            busy_d  = 1'b0;
                            state_d = IDLE;
                        end else begin
                            state_d = SERVICE;
                        end
                    end
                end
                SERVICE: begin
                    lfsr_step = 1'b1;
                    if (desc_bit) svc_err_d = 1'b1;
                    if (bit_cnt_q == 16'(SERVICE_BITS - 1)) state_d = DATA;
                end
                DATA: begin
                    lfsr_step   = 1'b1;
                    out_valid_d = 1'b1;
                    out_bit_d   = desc_bit;
                    if (bit_cnt_q == data_last) begin
                        out_last_d = 1'b1;
                        state_d    = TAIL;
                    end
                end
                TAIL: begin
                    lfsr_step = 1'b1;
                    if (bit_cnt_q == tail_last) begin
                        if (sym_last) begin
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            state_d = IDLE;
                        end else begin
                            state_d = PAD;
                        end
                    end
                end
                PAD: begin
                    lfsr_step = 1'b1;
                    if (sym_last) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= IDLE;
            len_q       <= '0;
            ndbps_q     <= '0;
            bit_cnt_q   <= '0;
            sym_cnt_q   <= '0;
            seed_q      <= 7'h7F;
            out_valid_q <= 1'b0;
            out_bit_q   <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            svc_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            ndbps_q     <= ndbps_d;
            bit_cnt_q   <= bit_cnt_d;
            sym_cnt_q   <= sym_cnt_d;
            seed_q      <= seed_d;
            out_valid_q <= out_valid_d;
            out_bit_q   <= out_bit_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            svc_err_q   <= svc_err_d;
        end
    end

    assign Out_Valid   = out_valid_q;
    assign Out_Bit     = out_bit_q;
    assign Out_Last    = out_last_q;
    assign Done        = done_q;
    assign Busy        = busy_q;
    assign Seed        = seed_q;
    assign Err         = err_q;
    assign Service_Err = svc_err_q;

endmodule

// File: tb/tb_descrambler_ctrl.sv
// Scoreboard bench for descrambler_ctrl: a scrambler model feeds frames, expected
// PSDU bits are queued at drive time and checked by an independent monitor.
module tb_descrambler_ctrl;

    logic        Clock = 1'b0;
    logic        Reset_n = 1'b0;
    logic        Start = 1'b0;
    logic [11:0] Length = '0;
    logic [7:0]  Ndbps = '0;
    logic        In_Valid = 1'b0;
    logic        In_Bit = 1'b0;
    logic        Out_Valid, Out_Bit, Out_Last, Done, Busy, Err, Service_Err;
    logic [6:0]  Seed;

    int total = 0;
    int bad = 0;
    logic [1:0] exp_q [$];   // {bit, last}
    logic vin_prev = 1'b0;

    descrambler_ctrl #(.MAX_LEN(4095)) dut (
        .Clock       (Clock),
        .Reset_n     (Reset_n),
        .Start       (Start),
        .Length      (Length),
        .Ndbps       (Ndbps),
        .In_Valid    (In_Valid),
        .In_Bit      (In_Bit),
        .Out_Valid   (Out_Valid),
        .Out_Bit     (Out_Bit),
        .Out_Last    (Out_Last),
        .Done        (Done),
        .Busy        (Busy),
        .Seed        (Seed),
        .Err         (Err),
        .Service_Err (Service_Err)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge Clock) vin_prev <= In_Valid;

    // Monitor: every output bit must match the head of the expected queue.
    always @(negedge Clock) begin
        if (Reset_n && Out_Valid) begin
            logic [1:0] e;
            chk("strobe_after_valid", {31'd0, vin_prev}, 32'd1);
            if (exp_q.size() == 0) begin
                chk("unexpected_out", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("out_bit", {31'd0, Out_Bit}, {31'd0, e[1]});
                chk("out_last", {31'd0, Out_Last}, {31'd0, e[0]});
            end
        end
    end

    task automatic do_start(input int len, input int nd);
        @(negedge Clock);
        Start = 1'b1;
        Length = 12'(len);
        Ndbps = 8'(nd);
        @(negedge Clock);
        Start = 1'b0;
    endtask

    // Sends one frame scrambled with 'seed'. flip_idx marks a SERVICE bit sent as 1;
    // abort_at >= 0 asserts reset just after that many bits have been consumed.
    task automatic run_frame(input logic [6:0] seed, input int len, input int nd,
                             input logic [7:0] b0, input bit gaps, input int flip_idx,
                             input int abort_at);
        logic sv [0:1023];
        logic d;
        logic [7:0] bt;
        int pre, tot, k;
        pre = 16 + 8 * len + 6;
        tot = ((pre + nd - 1) / nd) * nd;
        for (int n = 0; n < tot; n++) begin
            if (n < 7) sv[n] = seed[6-n];
            else       sv[n] = sv[n-7] ^ sv[n-4];
        end
        do_start(len, nd);
        chk("busy_after_start", {31'd0, Busy}, 32'd1);
        for (int n = 0; n < tot; n++) begin
            if (n == abort_at) begin
                Reset_n = 1'b0;
                In_Valid = 1'b0;
                #1;
                chk("rst_busy", {31'd0, Busy}, 32'd0);
                chk("rst_seed", {25'd0, Seed}, 32'h7F);
                chk("rst_outvalid", {31'd0, Out_Valid}, 32'd0);
                exp_q.delete();
                @(negedge Clock);
                Reset_n = 1'b1;
                return;
            end
            if (gaps && $urandom_range(0, 2) == 0) begin
                @(negedge Clock);
                In_Valid = 1'b0;
            end
            d = (n == flip_idx);
            if (n >= 16 && n < 16 + 8 * len) begin
                k = (n - 16) / 8;
                bt = b0 ^ 8'(k * 37);
                d = bt[(n-16)%8];
                exp_q.push_back({d, logic'(n == 16 + 8 * len - 1)});
            end
            @(negedge Clock);
            if (n == tot - 1) chk("done_not_early", {31'd0, Done}, 32'd0);
            In_Valid = 1'b1;
            In_Bit = d ^ sv[n];
        end
        @(negedge Clock);
        In_Valid = 1'b0;
        chk("done_pulse", {31'd0, Done}, 32'd1);
        chk("busy_end", {31'd0, Busy}, 32'd0);
        chk("seed_recovered", {25'd0, Seed}, {25'd0, seed});
        chk("service_err", {31'd0, Service_Err}, {31'd0, logic'(flip_idx >= 0)});
        @(negedge Clock);
        chk("done_one_cycle", {31'd0, Done}, 32'd0);
        chk("queue_drained", exp_q.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge Clock);
        chk("reset_busy", {31'd0, Busy}, 32'd0);
        chk("reset_seed", {25'd0, Seed}, 32'h7F);
        chk("reset_outs", {28'd0, Out_Valid, Out_Last, Done, Err}, 32'd0);
        chk("reset_svc", {31'd0, Service_Err}, 32'd0);
        Reset_n = 1'b1;

        // Seed 7F, one byte, 48-bit frame.
        run_frame(7'h7F, 1, 24, 8'hA5, 1'b0, -1, -1);
        // Four bytes, 54 bits padded to 72.
        run_frame(7'h5D, 4, 24, 8'h3C, 1'b0, -1, -1);

        // Illegal Starts.
        do_start(0, 24);
        chk("err_len0", {31'd0, Err}, 32'd1);
        chk("busy_len0", {31'd0, Busy}, 32'd0);
        @(negedge Clock);
        chk("err_len0_pulse", {31'd0, Err}, 32'd0);
        do_start(3, 25);
        chk("err_nd25", {31'd0, Err}, 32'd1);
        chk("busy_nd25", {31'd0, Busy}, 32'd0);

        // All-zero seed.
        do_start(2, 48);
        for (int n = 0; n < 7; n++) begin
            if (n == 6) chk("zero_seed_no_early_err", {31'd0, Err}, 32'd0);
            In_Valid = 1'b1;
            In_Bit = 1'b0;
            @(negedge Clock);
        end
        chk("zero_seed_err", {31'd0, Err}, 32'd1);
        chk("zero_seed_idle", {31'd0, Busy}, 32'd0);
        for (int n = 0; n < 20; n++) begin
            In_Bit = n[0];
            @(negedge Clock);
        end
        In_Valid = 1'b0;
        chk("zero_seed_err_pulse", {31'd0, Err}, 32'd0);

        // Reserved SERVICE bit 9 flipped, random input gaps.
        run_frame(7'h2A, 2, 48, 8'hC3, 1'b1, 9, -1);

        // Reset in DATA, then a clean frame.
        run_frame(7'h11, 4, 24, 8'h96, 1'b0, -1, 40);
        run_frame(7'h4B, 3, 36, 8'h0F, 1'b0, -1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/descrambler_ctrl.md
# descrambler_ctrl

Receive-side sequencer for the 802.11a PLCP DATA descrambler (S(x) = x^7 + x^4 + 1). It sits between the Viterbi decoder output and the MAC byte packer.
- Recovers the scrambler seed from the first 7 SERVICE bits, which are transmitted as zeros.
- Loads and steps its descrambler LFSR.
- Strips SERVICE, tail and pad bits, and forwards only the descrambled PSDU bits with framing strobes.

## Interface
- MAX_LEN, 4095: maximum PSDU length in bytes accepted from the SIGNAL field.
- Clock  in  1  system clock, all state on rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Start  in  1  one-cycle pulse, frame begins; samples Length and Ndbps. Ignored unless Busy=0.
- Length  in  12  PSDU length in bytes, legal range 1..MAX_LEN.
- Ndbps  in  8  data bits per OFDM symbol; legal values 24, 36, 48, 72, 96, 144, 192, 216.
- In_Valid  in  1  In_Bit is valid this cycle. No backpressure.
- In_Bit  in  1  scrambled decoded bit, in air order.
- Out_Valid  out  1  Out_Bit is a descrambled PSDU bit.
- Out_Bit  out  1  descrambled PSDU bit.
- Out_Last  out  1  set with the final PSDU bit.
- Done  out  1  one-cycle pulse after the last pad bit of the final symbol is consumed.
- Busy  out  1  frame in progress.
- Seed  out  7  recovered LFSR state [7:1]; holds until the next Start.
- Err  out  1  one-cycle pulse on an illegal Start or an all-zero seed.
- Service_Err  out  1  sticky per frame: a reserved SERVICE bit (7..15) descrambled to 1. Cleared by Start.

## Operation
- Reset values:
  - Out_Valid, Out_Bit, Out_Last, Done, Busy, Err, Service_Err = 0.
  - Seed = 7'h7F.
  - FSM = IDLE.
- IDLE:
  - Start with legal Length and Ndbps: latch both, clear counters, go to SEED, Busy=1.
  - Illegal Start (Length=0, Length>MAX_LEN, or Ndbps not in the legal set): Err pulse, stay IDLE.
- SEED (7 bits):
  - Shift In_Bit into the seed register, MSB first: the first bit lands in [7], the seventh in [1].
  - On the 7th bit, load the LFSR with the register contents.
  - If the contents are 0: Err pulse, go to IDLE.
  - Otherwise go to SERVICE.
- In every descramble state, each valid bit computes:
  - fb = lfsr[7]^lfsr[4]
  - out = In_Bit^fb
  - lfsr <= {lfsr[6:1], fb}
- SERVICE (9 bits, 7..15): descramble and discard; any out=1 sets Service_Err. Then go to DATA.
- DATA (8·Length bits): Out_Valid=1, Out_Bit=out; Out_Last on bit 8·Length-1. Then go to TAIL.
- TAIL (6 bits): consume only, no output. LFSR keeps stepping.
- PAD:
  - Consume bits until the symbol bit counter wraps.
  - If TAIL ends exactly on a symbol boundary, skip PAD.
- On the final symbol-boundary bit: Done pulse, Busy=0, go to IDLE.
- Counters:
  - Frame bit counter: 16 bit, largest frame is 16+32760+6 bits before pad.
  - Symbol counter: 8 bit, counts 0..Ndbps-1, wraps on every valid bit from the first SEED bit onward.
- Start while Busy: ignored. The frame continues.
- Reset_n low mid-frame: all outputs return to reset values immediately. Partial frame discarded.
- In_Valid=0: no state advances and all strobes are low.

## Timing
- All outputs are registered. Out_Valid/Out_Bit/Out_Last appear one cycle after the In_Valid cycle that carried the bit.
- Err appears the cycle after the offending Start, or after the 7th SEED bit.
- Done appears one cycle after the final pad bit is accepted.
- Back-to-back frames: Start is accepted in the same cycle Done is high (FSM is already IDLE).
- Throughput: one bit per clock sustained.
- First PSDU bit output: one cycle after the 17th valid input bit.

## Structure
- Shared package `plcp_rx_pkg`:
  - FSM state enum {IDLE, SEED, SERVICE, DATA, TAIL, PAD}.
  - SERVICE_BITS=16, SEED_BITS=7, TAIL_BITS=6.
  - Legal Ndbps constant list.
- One sub-module `descrambler_lfsr`: 7-bit LFSR, polynomial x^7+x^4+1, synchronous load port and step enable, combinational fb output.
- Everything else (FSM, counters, strobes) stays in descrambler_ctrl.

## Test plan
- Seed recovery: frame scrambled with seed 7'h7F, Length=1, Ndbps=24 → Seed=7'h7F. Eight Out_Valid bits equal the original byte, Out_Last on the 8th.
  - Frame length 30 bits → 18 pad bits, 48 bits total.
  - Done one cycle after the 48th bit.
- Boundary, no PAD: Length=1, Ndbps=30 is illegal, so use Length=4, Ndbps=24 (16+32+6=54) → PAD of 18 bits, Done after bit 72.
- Illegal Start: Length=0 → Err pulse next cycle, Busy stays 0. Also Ndbps=25 → Err pulse.
- All-zero seed: first 7 input bits 0 → Err after 7th bit, back to IDLE, no Out_Valid.
- SERVICE error and gaps: reserved bit 9 flipped with random In_Valid gaps → Service_Err=1 through the end of the frame. PSDU output unaffected. No strobes on gap cycles.
- Reset mid-DATA: Reset_n low at bit 40 → Busy=0 and Seed=7'h7F. A following legal frame decodes correctly.
